// File: rtl/adc_responder.sv
// Serial ADC target model: answers an SPI-style initiator with a 16-bit frame
// {2'b00, sample[11:0], 2'b00}, MSB first, sourced from sample_in or an internal ramp.
module adc_responder #(
  parameter logic [11:0] RAMP_STEP = 12'd1,
  parameter int          MIN_HALF  = 4
) (
  input  logic        osc_clk,
  input  logic        reset,
  input  logic        adc_clk,
  input  logic        adc_conv,
  input  logic [11:0] sample_in,
  input  logic        mode,
  output logic        adc_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [1:0]  state_dbg
);

  // Two sync flops plus one edge register put detected edges 3 cycles late,
  // so an adc_clk half-period below 4 cycles cannot be honoured.
  if (MIN_HALF < 4) begin : g_min_half_check
    $error("adc_responder: MIN_HALF must be at least 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  conv_sync, clk_sync;
  logic        conv_d, clk_d;
  logic        conv_rise, conv_fall, clk_rise, clk_fall;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        sampled;
  logic        mode_q;
  logic [11:0] ramp;
  logic [15:0] frame_word;
  logic        load, rise_en, shift_en, complete;

  // Reset values match the idle levels of the lines so release makes no edge.
  always_ff @(posedge osc_clk) begin
    if (reset) begin
      conv_sync <= 2'b11;
      conv_d    <= 1'b1;
      clk_sync  <= 2'b00;
      clk_d     <= 1'b0;
    end else begin
      conv_sync <= {conv_sync[0], adc_conv};
      conv_d    <= conv_sync[1];
      clk_sync  <= {clk_sync[0], adc_clk};
      clk_d     <= clk_sync[1];
    end
  end

  assign conv_rise = conv_sync[1] & ~conv_d;
  assign conv_fall = ~conv_sync[1] & conv_d;
  assign clk_rise  = clk_sync[1] & ~clk_d;
  assign clk_fall  = ~clk_sync[1] & clk_d;

  assign frame_word = {2'b00, (mode ? ramp : sample_in), 2'b00};

  always_ff @(posedge osc_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A conv rise coinciding with the 16th clock rise still counts as a full frame.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    rise_en    = 1'b0;
    shift_en   = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (conv_fall) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (clk_rise && bit_cnt == 5'd15) begin
          rise_en    = 1'b1;
          complete   = 1'b1;
          state_next = conv_rise ? IDLE : DONE;
        end else if (conv_rise) begin
          state_next = IDLE;
        end else if (clk_rise) begin
          rise_en = 1'b1;
        end else if (clk_fall && sampled) begin
          shift_en = 1'b1;
        end
      end
      DONE: begin
        if (conv_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      shreg       <= 16'd0;
      bit_cnt     <= 5'd0;
      sampled     <= 1'b0;
      mode_q      <= 1'b0;
      ramp        <= 12'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_done <= complete;
      if (load) begin
        shreg   <= frame_word;
        bit_cnt <= 5'd0;
        sampled <= 1'b0;
        mode_q  <= mode;
      end
      if (rise_en) begin
        sampled <= 1'b1;
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (shift_en) begin
        shreg   <= {shreg[14:0], 1'b0};
        sampled <= 1'b0;
      end
      if (complete) begin
        frame_count <= frame_count + 16'd1;
        if (mode_q) ramp <= ramp + RAMP_STEP;
      end
    end
  end

  // The current bit sits in shreg[15]; outside SHIFT the line is held low.
  assign adc_data  = (state == SHIFT) & shreg[15];
  assign busy      = (state == SHIFT);
  assign state_dbg = state;

endmodule

// File: doc/adc_responder.md
ADC_RESPONDER -- requirements
Module: adc_responder

Interface
REQ-001 Parameter RAMP_STEP, default 12'd1, ramp increment per completed frame in ramp mode.
REQ-002 Parameter MIN_HALF, default 4, minimum adc_clk half-period in osc_clk cycles the block SHALL support.
REQ-003 osc_clk  input  1  sole clock; all state updates on posedge osc_clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 adc_clk  input  1  serial clock from the ADC initiator, asynchronous to osc_clk.
REQ-006 adc_conv  input  1  conversion/frame strobe from the initiator, asynchronous; high = idle, low = frame active.
REQ-007 sample_in  input  12  external sample value, used when mode=0.
REQ-008 mode  input  1  0 = external sample_in, 1 = internal ramp.
REQ-009 adc_data  output  1  serial data to the initiator, MSB first.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 frame_done  output  1  one-cycle pulse on completion of a full 16-bit frame.
REQ-012 frame_count  output  16  count of completed frames, wraps at 16'hFFFF->0.

Function
REQ-013 adc_clk and adc_conv SHALL each pass through a 2-flop synchronizer followed by one edge-detect register; detected edges are 3 osc_clk cycles late.
REQ-014 Frame word SHALL be {2'b00, sample[11:0], 2'b00}; bit 15 transmitted first.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 IDLE: adc_data=0, busy=0; on detected adc_conv falling edge -> SHIFT, latch sample (sample_in if mode=0, ramp value if mode=1) into a 16-bit shift register, drive adc_data=frame[15] on the next cycle, clear bit counter and the sampled flag.
REQ-017 SHIFT: a detected adc_clk rising edge SHALL set the sampled flag and increment the bit counter (5 bits).
REQ-018 SHIFT: a detected adc_clk falling edge SHALL shift the next bit onto adc_data only if the sampled flag is set, then clear the flag; falling edges before the first rising edge SHALL NOT shift.
REQ-019 On the 16th detected rising edge, the FSM SHALL go to DONE, pulse frame_done for one cycle, increment frame_count, and in mode=1 add RAMP_STEP to the ramp modulo 4096.
REQ-020 DONE: adc_data=0, busy=0, further adc_clk edges ignored; detected adc_conv rising edge -> IDLE.
REQ-021 Detected adc_conv rising edge while in SHIFT SHALL abort: -> IDLE, adc_data=0, no frame_done, no frame_count or ramp update.
REQ-022 Simultaneous detected adc_conv rising edge and 16th adc_clk rising edge SHALL be treated as completion (frame_done, count update), then -> IDLE.
REQ-023 adc_conv falling edge detected in DONE or SHIFT SHALL be ignored; a new frame starts only from IDLE.
REQ-024 mode and sample_in SHALL be sampled only at frame start; changes mid-frame have no effect on the current frame.
REQ-025 adc_data SHALL be stable from one osc_clk after a shift until the next shift; with adc_clk half-period >= MIN_HALF the bit SHALL be valid at the initiator's rising edge.

Reset
REQ-026 While reset is high: state=IDLE, adc_data=0, busy=0, frame_done=0, frame_count=0, ramp=0, shift register=0, bit counter=0, sampled flag=0.
REQ-027 Synchronizer stages SHALL reset to adc_conv=1 and adc_clk=0 so that deassertion creates no spurious edge.
REQ-028 Reset asserted mid-frame SHALL abort without frame_done; after release, the block waits for a fresh adc_conv falling edge.

Verification
REQ-029 mode=0, sample_in=12'hABC, adc_clk period 128 cycles, conv low for 18 adc_clk periods -> initiator captures 16'h2AF0, bits[13:6]=8'hAB, one frame_done pulse, frame_count=1.
REQ-030 mode=1, RAMP_STEP=1, four complete frames -> captured samples 0,1,2,3; frame_count=4.
REQ-031 mode=1, ramp preloaded by 4095 completed frames -> next frame sends 12'hFFF, following frame sends 12'h000.
REQ-032 conv raised after 7 adc_clk rising edges -> busy falls 3 cycles later, no frame_done, frame_count and ramp unchanged; next full frame carries the unchanged sample.
REQ-033 reset pulsed during bit 9 of a frame -> all outputs at reset values next cycle; next full frame completes normally with frame_count=1.
REQ-034 adc_clk half-period exactly MIN_HALF=4 cycles, sample_in=12'h555 -> all 16 bits captured correctly (16'h1554).
